ext_bus_arbiter: RTL and testbench

//   Shares the external program-memory pad bus (10-bit address out, 8-bit data in) between two

---
 rtl/ext_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_ext_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_arbiter.sv
// Two-requester arbiter for the external program-memory pad bus (CPU fetch vs. debug port).
// Each granted read holds mem_addr for WAIT_CYCLES+1 cycles, then captures mem_data.
module ext_bus_arbiter #(
    parameter int AW          = 10,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_oe,
    input  logic [DW-1:0] mem_data,
    output logic          busy
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } owner_e;

    state_e        state_q;
    owner_e        owner_q;
    owner_e        last_owner_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] mem_addr_q;
    logic          access_q;
    logic          cpu_gnt_q;
    logic          dbg_gnt_q;
    logic          cpu_rvalid_q;
    logic          dbg_rvalid_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dbg_rdata_q;

    logic          cpu_elig;
    logic          dbg_elig;
    owner_e        pick_d;

    // A halted CPU (dbg_lock) is simply not eligible, so a tie can only occur with lock low.
    always_comb begin
        cpu_elig = cpu_req && !dbg_lock;
        dbg_elig = dbg_req;
        pick_d   = OWN_CPU;
        if (dbg_elig && (!cpu_elig || last_owner_q == OWN_CPU)) begin
            pick_d = OWN_DBG;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_DBG;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            access_q     <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_elig || dbg_elig) begin
                        owner_q      <= pick_d;
                        last_owner_q <= pick_d;
                        mem_addr_q   <= (pick_d == OWN_DBG) ? dbg_addr : cpu_addr;
                        cpu_gnt_q    <= (pick_d == OWN_CPU);
                        dbg_gnt_q    <= (pick_d == OWN_DBG);
                        access_q     <= 1'b1;
                        cnt_q        <= CW'(WAIT_CYCLES);
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        if (owner_q == OWN_DBG) begin
                            dbg_rdata_q  <= mem_data;
                            dbg_rvalid_q <= 1'b1;
                        end else begin
                            cpu_rdata_q  <= mem_data;
                            cpu_rvalid_q <= 1'b1;
                        end
                        access_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign dbg_gnt    = dbg_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_oe     = access_q;
    assign busy       = access_q;

    // Grants happen only from IDLE and rvalids only when leaving ACCESS, so at most one strobe is high.
    a_one_strobe: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({cpu_gnt_q, dbg_gnt_q, cpu_rvalid_q, dbg_rvalid_q}));

    a_oe_is_busy: assert property (@(posedge clk) disable iff (!rst)
        access_q == (state_q == ACCESS));

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Bench for ext_bus_arbiter: two instances (WAIT_CYCLES=2 and 0) on shared stimulus,
// checked every cycle against a timestamp-based transaction model plus directed literal checks.
module tb_ext_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_req = 1'b0;
    logic [9:0] cpu_addr = '0;
    logic       dbg_req = 1'b0;
    logic [9:0] dbg_addr = '0;
    logic       dbg_lock = 1'b0;
    logic [7:0] mem_data = '0;

    logic       cpu_gnt_w    [2];
    logic       cpu_rvalid_w [2];
    logic [7:0] cpu_rdata_w  [2];
    logic       dbg_gnt_w    [2];
    logic       dbg_rvalid_w [2];
    logic [7:0] dbg_rdata_w  [2];
    logic [9:0] mem_addr_w   [2];
    logic       mem_oe_w     [2];
    logic       busy_w       [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ext_bus_arbiter #(.AW(10), .DW(8), .WAIT_CYCLES((g == 0) ? 2 : 0)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .cpu_req    (cpu_req),
            .cpu_addr   (cpu_addr),
            .cpu_gnt    (cpu_gnt_w[g]),
            .cpu_rvalid (cpu_rvalid_w[g]),
            .cpu_rdata  (cpu_rdata_w[g]),
            .dbg_req    (dbg_req),
            .dbg_addr   (dbg_addr),
            .dbg_lock   (dbg_lock),
            .dbg_gnt    (dbg_gnt_w[g]),
            .dbg_rvalid (dbg_rvalid_w[g]),
            .dbg_rdata  (dbg_rdata_w[g]),
            .mem_addr   (mem_addr_w[g]),
            .mem_oe     (mem_oe_w[g]),
            .mem_data   (mem_data),
            .busy       (busy_w[g])
        );
    end

    // Transaction model: a read granted at edge n captures mem_data at edge n+W+1.
    int unsigned ecount = 0;
    logic        m_busy     [2];
    logic        m_own_dbg  [2];
    logic        m_last_dbg [2];
    int unsigned m_cap      [2];
    logic        e_cgnt [2];
    logic        e_crv  [2];
    logic [7:0]  e_crd  [2];
    logic        e_dgnt [2];
    logic        e_drv  [2];
    logic [7:0]  e_drd  [2];
    logic [9:0]  e_addr [2];
    logic        e_oe   [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_own_dbg[k] = 1'b0; m_last_dbg[k] = 1'b1; m_cap[k] = 0;
            e_cgnt[k] = 1'b0; e_crv[k] = 1'b0; e_crd[k] = '0;
            e_dgnt[k] = 1'b0; e_drv[k] = 1'b0; e_drd[k] = '0;
            e_addr[k] = '0;   e_oe[k] = 1'b0;
        end
    endfunction

    function automatic void model_step(int k);
        int unsigned w;
        logic celig, delig, pdbg;
        w = (k == 0) ? 2 : 0;
        e_cgnt[k] = 1'b0; e_dgnt[k] = 1'b0; e_crv[k] = 1'b0; e_drv[k] = 1'b0;
        if (m_busy[k]) begin
            if (ecount == m_cap[k]) begin
                if (m_own_dbg[k]) begin e_drd[k] = mem_data; e_drv[k] = 1'b1; end
                else              begin e_crd[k] = mem_data; e_crv[k] = 1'b1; end
                m_busy[k] = 1'b0;
                e_oe[k]   = 1'b0;
            end
        end else begin
            celig = cpu_req && !dbg_lock;
            delig = dbg_req;
            if (celig || delig) begin
                pdbg          = delig && (!celig || !m_last_dbg[k]);
                m_own_dbg[k]  = pdbg;
                m_last_dbg[k] = pdbg;
                e_addr[k]     = pdbg ? dbg_addr : cpu_addr;
                e_cgnt[k]     = !pdbg;
                e_dgnt[k]     = pdbg;
                e_oe[k]       = 1'b1;
                m_busy[k]     = 1'b1;
                m_cap[k]      = ecount + w + 1;
            end
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
        if (rst) ecount = ecount + 1;
    end

    function automatic logic [31:0] act_pack(int k);
        return {cpu_gnt_w[k], cpu_rvalid_w[k], cpu_rdata_w[k], dbg_gnt_w[k], dbg_rvalid_w[k],
                dbg_rdata_w[k], mem_addr_w[k], mem_oe_w[k], busy_w[k]};
    endfunction

    function automatic logic [31:0] exp_pack(int k);
        return {e_cgnt[k], e_crv[k], e_crd[k], e_dgnt[k], e_drv[k], e_drd[k],
                e_addr[k], e_oe[k], e_oe[k]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            chk((k == 0) ? "model_w2_outputs" : "model_w0_outputs", act_pack(k), exp_pack(k));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
        cpu_addr = '0; dbg_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    int nrv;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state_w2", act_pack(0), 32'h0);
        chk("reset_state_w0", act_pack(1), 32'h0);

        // CPU read at 0x155 with mem_data 0xA5
        rst = 1'b1; cpu_req = 1'b1; cpu_addr = 10'h155; mem_data = 8'hA5;
        @(negedge clk);
        chk("t1_cpu_gnt_c1", {31'b0, cpu_gnt_w[0]}, 32'd1);
        chk("t1_oe_c1", {31'b0, mem_oe_w[0]}, 32'd1);
        chk("t1_addr_c1", {22'b0, mem_addr_w[0]}, 32'h155);
        chk("t1_w0_gnt_c1", {31'b0, cpu_gnt_w[1]}, 32'd1);
        cpu_req = 1'b0; cpu_addr = '0;
        @(negedge clk);
        chk("t1_w0_rvalid_c2", {31'b0, cpu_rvalid_w[1]}, 32'd1);
        chk("t1_w0_rdata_c2", {24'b0, cpu_rdata_w[1]}, 32'hA5);
        chk("t1_oe_c2", {31'b0, mem_oe_w[0]}, 32'd1);
        @(negedge clk);
        chk("t1_oe_c3", {31'b0, mem_oe_w[0]}, 32'd1);
        chk("t1_no_rvalid_c3", {31'b0, cpu_rvalid_w[0]}, 32'd0);
        @(negedge clk);
        chk("t1_rvalid_c4", {31'b0, cpu_rvalid_w[0]}, 32'd1);
        chk("t1_rdata_c4", {24'b0, cpu_rdata_w[0]}, 32'hA5);
        chk("t1_oe_off_c4", {31'b0, mem_oe_w[0]}, 32'd0);
        chk("t1_dbg_quiet", {30'b0, dbg_gnt_w[0], dbg_rvalid_w[0]}, 32'd0);

        // Both requesting, lock low: CPU, DBG, CPU, DBG, four cycles apart
        do_reset();
        cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 10'h0C3; dbg_addr = 10'h2E1;
        for (int i = 1; i <= 16; i++) begin
            mem_data = 8'($urandom);
            @(negedge clk);
            chk("t2_cpu_gnt_sched", {31'b0, cpu_gnt_w[0]}, {31'b0, (i == 1 || i == 9)});
            chk("t2_dbg_gnt_sched", {31'b0, dbg_gnt_w[0]}, {31'b0, (i == 5 || i == 13)});
        end

        // Locked CPU request is ignored until the lock drops
        do_reset();
        dbg_lock = 1'b1; cpu_req = 1'b1; cpu_addr = 10'h011;
        repeat (20) begin
            @(negedge clk);
            chk("t3_locked_idle", {30'b0, cpu_gnt_w[0], busy_w[0]}, 32'd0);
        end
        dbg_lock = 1'b0;
        @(negedge clk);
        chk("t3_gnt_after_unlock", {31'b0, cpu_gnt_w[0]}, 32'd1);

        // Asynchronous reset in the middle of an access
        do_reset();
        cpu_req = 1'b1; cpu_addr = 10'h0AA; mem_data = 8'h5C;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t4_async_zero_w2", act_pack(0), 32'h0);
        chk("t4_async_zero_w0", act_pack(1), 32'h0);
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1;
        @(negedge clk);
        chk("t4_first_tie_cpu", {30'b0, cpu_gnt_w[0], dbg_gnt_w[0]}, 32'd2);
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t4_no_stale_rvalid", {30'b0, cpu_rvalid_w[0], dbg_rvalid_w[0]}, 32'd0);
        end

        // Back-to-back CPU reads at the address extremes
        do_reset();
        cpu_req = 1'b1; cpu_addr = 10'h3FF; mem_data = 8'hFF;
        nrv = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (cpu_gnt_w[0]) begin
                if (cpu_addr == 10'h3FF) cpu_addr = 10'h000;
                else cpu_req = 1'b0;
            end
            if (cpu_rvalid_w[0]) begin
                chk("t5_rdata", {24'b0, cpu_rdata_w[0]}, (nrv == 0) ? 32'hFF : 32'h00);
                nrv++;
            end
            mem_data = (mem_addr_w[0] == 10'h3FF) ? 8'hFF : 8'h00;
        end
        chk("t5_two_reads", nrv, 32'd2);
        chk("t5_addr_holds", {22'b0, mem_addr_w[0]}, 32'h000);

        // Randomised traffic with occasional lock toggles and mid-cycle resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            cpu_req  = ($urandom_range(0, 3) != 0);
            dbg_req  = ($urandom_range(0, 2) == 0);
            cpu_addr = 10'($urandom);
            dbg_addr = 10'($urandom);
            mem_data = 8'($urandom);
            if ($urandom_range(0, 49) == 0) dbg_lock = !dbg_lock;
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b0;
                #1;
                chk("rand_async_zero_w2", act_pack(0), 32'h0);
                chk("rand_async_zero_w0", act_pack(1), 32'h0);
                @(negedge clk);
                rst = 1'b1;
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
